// File: rtl/set_job_scheduler_if.sv
// Requester + engine handshake bundle for set_job_scheduler.
// slave = scheduler side, master = requesters/engine side.
interface set_job_scheduler_if;
  logic [1:0] req_vld;
  logic [7:0] req0_central;
  logic [3:0] req0_radius;
  logic [7:0] req1_central;
  logic [3:0] req1_radius;
  logic [1:0] req_ack;
  logic       set_en;
  logic [7:0] set_central;
  logic [3:0] set_radius;
  logic       set_busy;
  logic       set_valid;
  logic [7:0] set_candidate;
  logic       res_valid;
  logic       res_id;
  logic [7:0] res_candidate;
  logic       sched_busy;
  logic       timeout_err;

  modport slave (
    input  req_vld, req0_central, req0_radius, req1_central, req1_radius,
           set_busy, set_valid, set_candidate,
    output req_ack, set_en, set_central, set_radius,
           res_valid, res_id, res_candidate, sched_busy, timeout_err
  );

  modport master (
    output req_vld, req0_central, req0_radius, req1_central, req1_radius,
           set_busy, set_valid, set_candidate,
    input  req_ack, set_en, set_central, set_radius,
           res_valid, res_id, res_candidate, sched_busy, timeout_err
  );
endinterface

// File: rtl/set_job_scheduler.sv
// Round-robin sharing of one SET candidate-counting engine between two requesters.
// Optional SET_SCHED_TIMEOUT_EN: WAIT budget of TIMEOUT_CYC cycles, expiry returns 8'hFF with timeout_err.
module set_job_scheduler #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic                clk,
  input logic                rst,
  set_job_scheduler_if.slave sif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef struct packed {
    logic [7:0] central;
    logic [3:0] radius;
  } job_t;

  state_t     state;
  logic       rr_ptr;
  logic       id;
  logic       gnt;
  logic       to_hit;
  job_t [1:0] jobs;

  always_comb begin
    jobs[0] = job_t'{central: sif.req0_central, radius: sif.req0_radius};
    jobs[1] = job_t'{central: sif.req1_central, radius: sif.req1_radius};
    // rr_ptr only decides when both requesters contend
    gnt = (sif.req_vld == 2'b11) ? rr_ptr : sif.req_vld[1];
  end

`ifdef SET_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wait_cnt <= '0;
    else if (state == ISSUE)                  wait_cnt <= '0;
    else if (state == WAIT && !sif.set_valid) wait_cnt <= wait_cnt + 8'd1;
  end

  assign to_hit = (wait_cnt == TO_LAST);
`else
  logic [7:0] unused_cfg;
  assign unused_cfg = 8'(TIMEOUT_CYC);
  assign to_hit     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= 1'b0;
      id                <= 1'b0;
      sif.req_ack       <= '0;
      sif.set_en        <= 1'b0;
      sif.set_central   <= '0;
      sif.set_radius    <= '0;
      sif.res_valid     <= 1'b0;
      sif.res_id        <= 1'b0;
      sif.res_candidate <= '0;
      sif.sched_busy    <= 1'b0;
      sif.timeout_err   <= 1'b0;
    end else begin
      sif.req_ack     <= '0;
      sif.set_en      <= 1'b0;
      sif.res_valid   <= 1'b0;
      sif.timeout_err <= 1'b0;
      unique case (state)
        IDLE: if (|sif.req_vld && !sif.set_busy) begin
          id              <= gnt;
          sif.set_central <= jobs[gnt].central;
          sif.set_radius  <= jobs[gnt].radius;
          sif.req_ack     <= gnt ? 2'b10 : 2'b01;
          sif.set_en      <= 1'b1;
          sif.sched_busy  <= 1'b1;
          state           <= ISSUE;
        end
        ISSUE: begin
          rr_ptr <= ~id;
          state  <= WAIT;
        end
        // a real result on the last budget cycle takes priority over the timeout
        WAIT: if (sif.set_valid || to_hit) begin
          sif.res_valid     <= 1'b1;
          sif.res_id        <= id;
          sif.res_candidate <= sif.set_valid ? sif.set_candidate : 8'hFF;
          sif.timeout_err   <= !sif.set_valid;
          state             <= DONE;
        end
        DONE: begin
          sif.sched_busy <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_job_scheduler.sv
// Self-checking bench for set_job_scheduler: scripted + randomized jobs against a job-level model.
`timescale 1ns/1ps
module tb_set_job_scheduler;
  localparam int unsigned TO_CYC = 20;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;
  int   rr_pref = 0;  // model: requester that wins the next tie

  always #5 clk = ~clk;

  set_job_scheduler_if ifc();

  set_job_scheduler #(.TIMEOUT_CYC(TO_CYC)) dut (
    .clk (clk),
    .rst (rst),
    .sif (ifc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] all_outs();
    return {ifc.req_ack, ifc.set_en, ifc.set_central, ifc.set_radius, ifc.res_valid,
            ifc.res_id, ifc.res_candidate, ifc.sched_busy, ifc.timeout_err};
  endfunction

  // One complete job from an IDLE cycle back to the following IDLE cycle.
  task automatic run_job(input logic [1:0] vld, input logic [7:0] c0, input logic [3:0] r0,
                         input logic [7:0] c1, input logic [3:0] r1, input logic [7:0] cand,
                         input int stall, input int lat, input bit noise, input bit hold);
    int w;
    logic [7:0] ec;
    logic [3:0] er;
    ifc.req0_central = c0; ifc.req0_radius = r0;
    ifc.req1_central = c1; ifc.req1_radius = r1;
    ifc.req_vld = vld;
    w  = (vld == 2'b01) ? 0 : (vld == 2'b10) ? 1 : rr_pref;
    ec = (w == 1) ? c1 : c0;
    er = (w == 1) ? r1 : r0;
    for (int s = 0; s < stall; s++) begin
      ifc.set_busy = 1'b1; ifc.set_valid = noise;
      step;
      nchk++;
      if ({ifc.req_ack, ifc.set_en, ifc.sched_busy, ifc.res_valid} !== 5'b0) begin
        nerr++;
        $display("FAIL stall_cycle%0d: got ack/en/busy/rv %b exp 00000", s,
                 {ifc.req_ack, ifc.set_en, ifc.sched_busy, ifc.res_valid});
      end
    end
    ifc.set_busy = 1'b0; ifc.set_valid = noise;
    step;  // ISSUE
    nchk++;
    if ({ifc.req_ack, ifc.set_en, ifc.set_central, ifc.set_radius, ifc.sched_busy, ifc.res_valid}
        !== {(w == 1) ? 2'b10 : 2'b01, 1'b1, ec, er, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL issue: got ack=%b en=%b c=%h r=%h busy=%b rv=%b exp ack=%b en=1 c=%h r=%h busy=1 rv=0",
               ifc.req_ack, ifc.set_en, ifc.set_central, ifc.set_radius, ifc.sched_busy,
               ifc.res_valid, (w == 1) ? 2'b10 : 2'b01, ec, er);
    end
    rr_pref = 1 - w;
    if (noise) begin
      ifc.req_vld = 2'($urandom); ifc.set_busy = 1'($urandom); ifc.set_valid = 1'b1;
      ifc.req0_central = 8'($urandom); ifc.req1_central = 8'($urandom);
    end else begin
      ifc.req_vld = hold ? vld : 2'b00; ifc.set_valid = 1'b0;
    end
    step;
    for (int k = 1; k <= lat; k++) begin
      nchk++;
      if ({ifc.req_ack, ifc.set_en, ifc.sched_busy, ifc.res_valid, ifc.set_central, ifc.set_radius}
          !== {4'b0001, 1'b0, ec, er}) begin
        nerr++;
        $display("FAIL wait_cycle%0d: got ack=%b en=%b busy=%b rv=%b c=%h r=%h exp 00 0 1 0 %h %h", k,
                 ifc.req_ack, ifc.set_en, ifc.sched_busy, ifc.res_valid, ifc.set_central,
                 ifc.set_radius, ec, er);
      end
      ifc.set_valid     = (k == lat);
      ifc.set_candidate = (k == lat) ? cand : 8'($urandom);
      if (noise) begin
        ifc.req_vld = 2'($urandom); ifc.set_busy = 1'($urandom);
      end
      step;
    end
    nchk++;  // DONE
    if ({ifc.res_valid, ifc.res_id, ifc.res_candidate, ifc.timeout_err, ifc.sched_busy, ifc.set_en, ifc.req_ack}
        !== {1'b1, 1'(w), cand, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      nerr++;
      $display("FAIL done: got rv=%b id=%b cand=%h terr=%b busy=%b exp rv=1 id=%0d cand=%h terr=0 busy=1",
               ifc.res_valid, ifc.res_id, ifc.res_candidate, ifc.timeout_err, ifc.sched_busy, w, cand);
    end
    ifc.set_valid = 1'b0; ifc.set_busy = 1'b0; ifc.set_candidate = 8'($urandom);
    ifc.req_vld = hold ? vld : 2'b00;
    step;  // IDLE
    nchk++;
    if ({ifc.res_valid, ifc.res_id, ifc.res_candidate, ifc.sched_busy, ifc.timeout_err, ifc.set_en,
         ifc.req_ack, ifc.set_central, ifc.set_radius} !== {1'b0, 1'(w), cand, 5'b0, ec, er}) begin
      nerr++;
      $display("FAIL idle_hold: got rv=%b id=%b cand=%h busy=%b c=%h r=%h exp rv=0 id=%0d cand=%h busy=0 c=%h r=%h",
               ifc.res_valid, ifc.res_id, ifc.res_candidate, ifc.sched_busy, ifc.set_central,
               ifc.set_radius, w, cand, ec, er);
    end
  endtask

  task automatic test_reset();
    #1;
    nchk++;
    if (all_outs() !== 27'd0) begin
      nerr++; $display("FAIL reset_state: got %h exp 0", all_outs());
    end
    step; step;
    rst = 1'b0; rr_pref = 0;
    ifc.req_vld = 2'b01; ifc.req0_central = 8'h5A; ifc.req0_radius = 4'd7;
    step;  // ISSUE of a job that will be dropped
    nchk++;
    if ({ifc.req_ack, ifc.set_en} !== 3'b011) begin
      nerr++; $display("FAIL pre_reset_issue: got ack/en %b exp 011", {ifc.req_ack, ifc.set_en});
    end
    rr_pref = 1; ifc.req_vld = 2'b00;
    step; step;
    rst = 1'b1;
    #1;
    nchk++;
    if (all_outs() !== 27'd0) begin
      nerr++; $display("FAIL reset_async: got %h exp 0", all_outs());
    end
    for (int i = 0; i < 3; i++) begin
      step;
      nchk++;
      if (all_outs() !== 27'd0) begin
        nerr++; $display("FAIL reset_hold%0d: got %h exp 0", i, all_outs());
      end
    end
    rst = 1'b0; rr_pref = 0;
    ifc.set_valid = 1'b1; ifc.set_candidate = 8'h77;  // late engine valid for the dropped job
    step;
    ifc.set_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nchk++;
      if ({ifc.res_valid, ifc.sched_busy} !== 2'b00) begin
        nerr++; $display("FAIL post_reset%0d: got rv/busy %b exp 00", i, {ifc.res_valid, ifc.sched_busy});
      end
      step;
    end
    run_job(2'b11, 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_single_job();
    run_job(2'b01, 8'h44, 4'd3, 8'($urandom), 4'($urandom), 8'd29, 0, 5, 1'b0, 1'b0);
  endtask

  task automatic test_contention();
    rst = 1'b1;
    step;
    rst = 1'b0; rr_pref = 0;
    for (int j = 0; j < 4; j++)
      run_job(2'b11, 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 8'($urandom),
              0, 4, 1'b0, j != 3);
  endtask

  task automatic test_busy_stall();
    run_job(2'b10, 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 10, 3, 1'b0, 1'b0);
  endtask

  task automatic test_valid_filter();
    ifc.req_vld = 2'b00; ifc.set_valid = 1'b1;
    step;
    ifc.set_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nchk++;
      if ({ifc.res_valid, ifc.sched_busy, ifc.set_en} !== 3'b000) begin
        nerr++; $display("FAIL idle_valid%0d: got rv/busy/en %b exp 000", i,
                         {ifc.res_valid, ifc.sched_busy, ifc.set_en});
      end
      step;
    end
    run_job(2'b01, 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 2, 3, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 40; j++)
      run_job(2'($urandom_range(1, 3)), 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom),
              8'($urandom), $urandom_range(0, 3), $urandom_range(1, 8), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_timeout();
    logic [7:0] c;
    c = 8'($urandom);
    ifc.req_vld = 2'b01; ifc.req0_central = c; ifc.set_valid = 1'b0;
    step;  // ISSUE
    nchk++;
    if ({ifc.set_en, ifc.req_ack, ifc.set_central} !== {3'b101, c}) begin
      nerr++; $display("FAIL to_issue: got en=%b ack=%b c=%h exp en=1 ack=01 c=%h",
                       ifc.set_en, ifc.req_ack, ifc.set_central, c);
    end
    rr_pref = 1; ifc.req_vld = 2'b00;
`ifdef SET_SCHED_TIMEOUT_EN
    for (int k = 1; k <= int'(TO_CYC); k++) begin
      step;
      nchk++;
      if ({ifc.res_valid, ifc.sched_busy} !== 2'b01) begin
        nerr++; $display("FAIL to_wait%0d: got rv/busy %b exp 01", k, {ifc.res_valid, ifc.sched_busy});
      end
    end
    step;
    nchk++;
    if ({ifc.res_valid, ifc.res_id, ifc.res_candidate, ifc.timeout_err} !== {2'b10, 8'hFF, 1'b1}) begin
      nerr++; $display("FAIL to_done: got rv=%b id=%b cand=%h terr=%b exp rv=1 id=0 cand=ff terr=1",
                       ifc.res_valid, ifc.res_id, ifc.res_candidate, ifc.timeout_err);
    end
    step;
    nchk++;
    if ({ifc.res_valid, ifc.timeout_err, ifc.sched_busy, ifc.res_candidate} !== {3'b000, 8'hFF}) begin
      nerr++; $display("FAIL to_idle: got rv=%b terr=%b busy=%b cand=%h exp 0 0 0 ff",
                       ifc.res_valid, ifc.timeout_err, ifc.sched_busy, ifc.res_candidate);
    end
    run_job(2'b10, 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 8'h3C, 0, TO_CYC, 1'b0, 1'b0);
    run_job(2'b01, 8'($urandom), 4'($urandom), 8'($urandom), 4'($urandom), 8'hC3, 0, TO_CYC - 1, 1'b0, 1'b0);
`else
    begin
      int seen = 0;
      for (int k = 0; k < 500; k++) begin
        step;
        if (ifc.res_valid !== 1'b0 || ifc.timeout_err !== 1'b0 || ifc.sched_busy !== 1'b1) seen++;
      end
      nchk++;
      if (seen != 0) begin
        nerr++; $display("FAIL no_timeout: got %0d cycles with rv/terr set or busy low exp 0", seen);
      end
    end
    rst = 1'b1;
    step;
    rst = 1'b0; rr_pref = 0;
    nchk++;
    if (all_outs() !== 27'd0) begin
      nerr++; $display("FAIL no_timeout_recover: got %h exp 0", all_outs());
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    ifc.req_vld = '0; ifc.req0_central = '0; ifc.req0_radius = '0;
    ifc.req1_central = '0; ifc.req1_radius = '0;
    ifc.set_busy = 1'b0; ifc.set_valid = 1'b0; ifc.set_candidate = '0;
    test_reset();
    test_single_job();
    test_contention();
    test_busy_stall();
    test_valid_filter();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
